// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, FSM encoding and token layout for the FFT frame sequencer.
package fft_pkg;
  localparam int N = 128;
  localparam int FRAME_CYC = N / 4;
  localparam int CNT_W = $clog2(FRAME_CYC);
  localparam int LATENCY_DEF = 12;
  localparam int NBITS_OUT = 21;
  typedef enum logic [1:0] {IDLE, RUN, PAD} stateT;
  typedef struct packed {
    logic vld;
    logic sop;
    logic eop;
  } tokenT;
  localparam int TOK_W = $bits(tokenT);
endpackage

// File: rtl/fft_token_delay.sv
// fft_token_delay: LATENCY-deep shift register with sync clear; anyVld ORs the MSB of every stage.
module fft_token_delay #(
  parameter int W = 4,
  parameter int LATENCY = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         anyVld
);
  logic [LATENCY-1:0][W-1:0] pipe;
  always_ff @(posedge clk or negedge rst)
    if (!rst) pipe <= '0;
    else if (clr) pipe <= '0;
    else pipe <= {pipe[LATENCY-2:0], d};
  always_comb begin
    anyVld = 1'b0;
    for (int i = 0; i < LATENCY; i++) anyVld = anyVld | pipe[i][W-1];
  end
  assign q = pipe[LATENCY-1];
endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: packs a valid/ready stream into contiguous FFT frames and tracks them through the core.
// Optional FFT_FRAME_STATS_EN adds frames_in/frames_out counters.
module fft_frame_ctrl import fft_pkg::*; #(
  parameter int NBITS = 10,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [8*NBITS-1:0] s_data,
  output logic [2*NBITS-1:0] fftIn0_up,
  output logic [2*NBITS-1:0] fftIn0_down,
  output logic [2*NBITS-1:0] fftIn1_up,
  output logic [2*NBITS-1:0] fftIn1_down,
  output logic               fftOut_valid,
  output logic               fftOut_sop,
  output logic               fftOut_eop,
  output logic               fftOut_bad,
  output logic               err_underrun,
  output logic               busy
`ifdef FFT_FRAME_STATS_EN
  ,
  output logic [15:0]        frames_in,
  output logic [15:0]        frames_out
`endif
);
  localparam int BAD_DEPTH = (LATENCY + FRAME_CYC - 1) / FRAME_CYC + 1;
  localparam int TAG_W = $clog2(BAD_DEPTH);
  stateT state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic accept, drive, underrun, startFrame, lastCyc, pipeBusy;
  logic [TAG_W-1:0] curTag, drvTag, drvTokTag, outTag;
  logic [BAD_DEPTH-1:0] badFlag;
  tokenT drvTok, outTok;
  logic [TOK_W+TAG_W-1:0] dlyIn, dlyOut;
  assign s_ready = rst && !flush && state != PAD;
  assign accept = s_valid && s_ready;
  always_comb begin
    drive = !flush && (state != IDLE || accept);
    startFrame = drive && state == IDLE;
    underrun = !flush && state == RUN && !s_valid;
    lastCyc = cnt == CNT_W'(FRAME_CYC - 1);
    cntNext = drive ? cnt + 1'b1 : '0;
    stateNext = (!drive || lastCyc) ? IDLE : (underrun || state == PAD) ? PAD : RUN;
    drvTag = !startFrame ? curTag : (curTag == TAG_W'(BAD_DEPTH - 1)) ? '0 : curTag + 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      curTag <= '0;
      badFlag <= '0;
      err_underrun <= 1'b0;
      drvTok <= '0;
      drvTokTag <= '0;
      {fftIn1_down, fftIn1_up, fftIn0_down, fftIn0_up} <= '0;
    end else begin
      state <= stateNext;
      cnt <= cntNext;
      curTag <= drvTag;
      if (startFrame) badFlag[drvTag] <= 1'b0;
      if (underrun) badFlag[curTag] <= 1'b1;
      err_underrun <= !flush && (err_underrun || underrun);
      drvTok <= '{vld: drive, sop: startFrame, eop: drive && lastCyc};
      drvTokTag <= drvTag;
      {fftIn1_down, fftIn1_up, fftIn0_down, fftIn0_up} <= accept ? s_data : '0;
    end
  // Bad is looked up by frame tag at the output so late underruns still mark earlier tokens.
  assign dlyIn = {drvTok, drvTokTag};
  assign {outTok, outTag} = dlyOut;
  fft_token_delay #(.W(TOK_W + TAG_W), .LATENCY(LATENCY)) u_delay (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .d(dlyIn),
    .q(dlyOut),
    .anyVld(pipeBusy)
  );
  assign fftOut_valid = outTok.vld;
  assign fftOut_sop = outTok.sop;
  assign fftOut_eop = outTok.eop;
  assign fftOut_bad = outTok.vld && badFlag[outTag];
  assign busy = state != IDLE || drvTok.vld || pipeBusy;
`ifdef FFT_FRAME_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      frames_in <= '0;
      frames_out <= '0;
    end else if (flush) begin
      frames_in <= '0;
      frames_out <= '0;
    end else begin
      if (startFrame) frames_in <= frames_in + 1'b1;
      if (outTok.vld && outTok.eop) frames_out <= frames_out + 1'b1;
    end
`endif
endmodule
